// File: rtl/apb_rr_master.sv
// Two-requester round-robin APB master: arbitrates, latches the winning command,
// runs SETUP/ACCESS with a bounded wait on pready, and returns the response to the winner.
module apb_rr_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  rsp_done,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_reg, last_next;
  logic          psel_reg, psel_next;
  logic          penable_reg, penable_next;
  logic          pwrite_reg, pwrite_next;
  logic [31:0]   paddr_reg, paddr_next;
  logic [31:0]   pwdata_reg, pwdata_next;
  logic [1:0]    rsp_done_reg, rsp_done_next;
  logic [31:0]   rsp_rdata_reg, rsp_rdata_next;
  logic          rsp_err_reg, rsp_err_next;
  logic          rsp_timeout_reg, rsp_timeout_next;

  logic [31:0]   addr_arr [2];
  logic [31:0]   wdata_arr [2];
  logic          win;
  logic          timeout_hit;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req_split
      assign addr_arr[gi]  = req_addr[32*gi +: 32];
      assign wdata_arr[gi] = req_wdata[32*gi +: 32];
    end
  endgenerate

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    win = ~last_reg;
    if (req_valid == 2'b01) begin
      win = 1'b0;
    end else if (req_valid == 2'b10) begin
      win = 1'b1;
    end
  end

  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      last_reg        <= 1'b1;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      rsp_done_reg    <= '0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      last_reg        <= last_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      pwrite_reg      <= pwrite_next;
      paddr_reg       <= paddr_next;
      pwdata_reg      <= pwdata_next;
      rsp_done_reg    <= rsp_done_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response fields default to zero so they only live for the single DONE cycle.
  always_comb begin
    cnt_next         = cnt_reg;
    last_next        = last_reg;
    psel_next        = psel_reg;
    penable_next     = penable_reg;
    pwrite_next      = pwrite_reg;
    paddr_next       = paddr_reg;
    pwdata_next      = pwdata_reg;
    rsp_done_next    = '0;
    rsp_rdata_next   = '0;
    rsp_err_next     = 1'b0;
    rsp_timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          last_next    = win;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          pwrite_next  = req_write[win];
          paddr_next   = addr_arr[win];
          pwdata_next  = wdata_arr[win];
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        cnt_next     = '0;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_next = pwrite_reg ? 32'h0 : prdata;
          rsp_err_next   = pslverr;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_done_next  = last_reg ? 2'b10 : 2'b01;
        end else if (timeout_hit) begin
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_done_next    = last_reg ? 2'b10 : 2'b01;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign psel        = psel_reg;
  assign penable     = penable_reg;
  assign pwrite      = pwrite_reg;
  assign paddr       = paddr_reg;
  assign pwdata      = pwdata_reg;
  assign rsp_done    = rsp_done_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule
